// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared constants and types for the multicycle CPU control
//                path. It holds the instruction opcodes, the ALU op_codes,
//                the datapath mux selects, the decoded instruction classes
//                and the one-hot control state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    // ------------------------------------------------------------------
    // Instruction opcodes (IR[31:28]).
    // 0x0-0x6 are R-type and carry the ALU op in their low bits.
    // 0x7 and 0xE are undefined.
    // ------------------------------------------------------------------
    localparam logic [3:0] c_op_r_last = 4'h6;
    localparam logic [3:0] c_op_addi   = 4'h8;
    localparam logic [3:0] c_op_lw     = 4'h9;
    localparam logic [3:0] c_op_sw     = 4'hA;
    localparam logic [3:0] c_op_beq    = 4'hB;
    localparam logic [3:0] c_op_bne    = 4'hC;
    localparam logic [3:0] c_op_j      = 4'hD;
    localparam logic [3:0] c_op_halt   = 4'hF;

    // ------------------------------------------------------------------
    // ALU op_codes. These must stay identical to the ALU's own encoding.
    // ------------------------------------------------------------------
    localparam logic [2:0] c_alu_mov = 3'b000;
    localparam logic [2:0] c_alu_not = 3'b001;
    localparam logic [2:0] c_alu_add = 3'b010;
    localparam logic [2:0] c_alu_sub = 3'b011;
    localparam logic [2:0] c_alu_or  = 3'b100;
    localparam logic [2:0] c_alu_and = 3'b101;
    localparam logic [2:0] c_alu_slt = 3'b110;

    // ------------------------------------------------------------------
    // Datapath mux selects
    // ------------------------------------------------------------------
    localparam logic       c_src_a_pc     = 1'b0;
    localparam logic       c_src_a_reg    = 1'b1;

    localparam logic [1:0] c_src_b_reg    = 2'b00;
    localparam logic [1:0] c_src_b_one    = 2'b01;
    localparam logic [1:0] c_src_b_imm    = 2'b10;

    localparam logic [1:0] c_pc_src_alu    = 2'b00;  // combinational ALU result
    localparam logic [1:0] c_pc_src_aluout = 2'b01;  // registered ALUOut
    localparam logic [1:0] c_pc_src_jump   = 2'b10;  // jump target

    localparam logic       c_iord_pc      = 1'b0;
    localparam logic       c_iord_aluout  = 1'b1;

    // ------------------------------------------------------------------
    // Decoded instruction class
    // ------------------------------------------------------------------
    typedef enum logic [3:0] {
        CLS_R    = 4'd0,
        CLS_ADDI = 4'd1,
        CLS_LW   = 4'd2,
        CLS_SW   = 4'd3,
        CLS_BEQ  = 4'd4,
        CLS_BNE  = 4'd5,
        CLS_J    = 4'd6,
        CLS_HALT = 4'd7,
        CLS_ILL  = 4'd8
    } op_class_e;

    // ------------------------------------------------------------------
    // Control states, one-hot. Any other bit pattern is treated as
    // corrupt and recovers to ST_FETCH on the next edge.
    // ------------------------------------------------------------------
    typedef enum logic [10:0] {
        ST_FETCH  = 11'b000_0000_0001,
        ST_DECODE = 11'b000_0000_0010,
        ST_EXEC_R = 11'b000_0000_0100,
        ST_EXEC_I = 11'b000_0000_1000,
        ST_MEM_RD = 11'b000_0001_0000,
        ST_MEM_WR = 11'b000_0010_0000,
        ST_WB_ALU = 11'b000_0100_0000,
        ST_WB_MEM = 11'b000_1000_0000,
        ST_BRANCH = 11'b001_0000_0000,
        ST_JUMP   = 11'b010_0000_0000,
        ST_HALT   = 11'b100_0000_0000
    } state_e;

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_decode
//  Description : Purely combinational instruction decoder. It maps the
//                opcode onto an instruction class, the ALU op_code used by
//                R-type execution and an undefined-opcode flag.
//  Ports       : i_opcode  - instruction opcode (IR[31:28])
//                o_class   - decoded instruction class
//                o_alu_op  - ALU op_code for R-type (opcode[2:0]), else MOV
//                o_illegal - opcode is undefined
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int ALUW = 3
) (
    input  logic [OPW-1:0]  i_opcode,
    output op_class_e       o_class,
    output logic [ALUW-1:0] o_alu_op,
    output logic            o_illegal
);

    always_comb begin
        o_class   = CLS_ILL;
        o_alu_op  = c_alu_mov;
        o_illegal = 1'b1;

        if (i_opcode <= c_op_r_last) begin
            // R-type opcodes carry the ALU operation in their low bits.
            o_class   = CLS_R;
            o_alu_op  = i_opcode[ALUW-1:0];
            o_illegal = 1'b0;
        end else begin
            case (i_opcode)
                c_op_addi: begin o_class = CLS_ADDI; o_illegal = 1'b0; end
                c_op_lw:   begin o_class = CLS_LW;   o_illegal = 1'b0; end
                c_op_sw:   begin o_class = CLS_SW;   o_illegal = 1'b0; end
                c_op_beq:  begin o_class = CLS_BEQ;  o_illegal = 1'b0; end
                c_op_bne:  begin o_class = CLS_BNE;  o_illegal = 1'b0; end
                c_op_j:    begin o_class = CLS_J;    o_illegal = 1'b0; end
                c_op_halt: begin o_class = CLS_HALT; o_illegal = 1'b0; end
                default:   begin o_class = CLS_ILL;  o_illegal = 1'b1; end
            endcase
        end
    end

endmodule : ctrl_decode
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Main control FSM of the multicycle CPU. It sequences the
//                shared ALU, the instruction register, the PC and the single
//                req/ready memory port through fetch, decode, execute,
//                memory and writeback states.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                opcode           - IR[31:28], valid from DECODE onward
//                zero             - ALU zero flag (a == b)
//                mem_ready        - memory completes current request
//                alu_op           - ALU operation
//                alu_src_a/b      - ALU operand selects
//                ir_write         - load IR from memory read data
//                pc_write, pc_src - PC load enable and source select
//                mem_req, mem_we  - memory request / write
//                iord             - memory address select (PC or ALUOut)
//                reg_write        - register file write
//                mem_to_reg       - writeback source (ALUOut or MDR)
//                halted           - FSM is in HALT
//                illegal          - sticky: undefined opcode decoded
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int ALUW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic [ALUW-1:0] alu_op,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic            ir_write,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic            mem_req,
    output logic            mem_we,
    output logic            iord,
    output logic            reg_write,
    output logic            mem_to_reg,
    output logic            halted,
    output logic            illegal
);

    state_e          state_q;
    state_e          state_d;
    logic            illegal_q;
    logic            illegal_d;
    // High for exactly the cycle after a reset edge: every output is held
    // at zero and FETCH does not issue its request until this clears.
    logic            blank_q;

    op_class_e       w_class;
    logic [ALUW-1:0] w_dec_alu_op;
    logic            w_dec_illegal;

    ctrl_decode #(
        .OPW  (OPW),
        .ALUW (ALUW)
    ) u_decode (
        .i_opcode  (opcode),
        .o_class   (w_class),
        .o_alu_op  (w_dec_alu_op),
        .o_illegal (w_dec_illegal)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
            blank_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            blank_q   <= 1'b0;
        end
    end

    assign illegal = illegal_q;

    // ------------------------------------------------------------------
    // Next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        alu_op     = c_alu_mov;
        alu_src_a  = c_src_a_pc;
        alu_src_b  = c_src_b_reg;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = c_pc_src_alu;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = c_iord_pc;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;

        if (blank_q) begin
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    // The ALU computes PC+1 while the fetch is outstanding so
                    // the PC can load it straight from the ALU on completion.
                    mem_req   = 1'b1;
                    iord      = c_iord_pc;
                    alu_src_a = c_src_a_pc;
                    alu_src_b = c_src_b_one;
                    alu_op    = c_alu_add;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = c_pc_src_alu;
                        state_d  = ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    // Speculative branch target (PC+1 + imm) into ALUOut.
                    alu_src_a = c_src_a_pc;
                    alu_src_b = c_src_b_imm;
                    alu_op    = c_alu_add;
                    if (w_dec_illegal) begin
                        illegal_d = 1'b1;
                    end
                    case (w_class)
                        CLS_R:    state_d = ST_EXEC_R;
                        CLS_ADDI: state_d = ST_EXEC_I;
                        CLS_LW:   state_d = ST_EXEC_I;
                        CLS_SW:   state_d = ST_EXEC_I;
                        CLS_BEQ:  state_d = ST_BRANCH;
                        CLS_BNE:  state_d = ST_BRANCH;
                        CLS_J:    state_d = ST_JUMP;
                        CLS_HALT: state_d = ST_HALT;
                        default:  state_d = ST_FETCH;
                    endcase
                end

                ST_EXEC_R: begin
                    alu_src_a = c_src_a_reg;
                    alu_src_b = c_src_b_reg;
                    alu_op    = w_dec_alu_op;
                    state_d   = ST_WB_ALU;
                end

                ST_EXEC_I: begin
                    // Serves ADDI as well as the LW/SW address calculation.
                    alu_src_a = c_src_a_reg;
                    alu_src_b = c_src_b_imm;
                    alu_op    = c_alu_add;
                    case (w_class)
                        CLS_LW:  state_d = ST_MEM_RD;
                        CLS_SW:  state_d = ST_MEM_WR;
                        default: state_d = ST_WB_ALU;
                    endcase
                end

                ST_MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = c_iord_aluout;
                    if (mem_ready) begin
                        state_d = ST_WB_MEM;
                    end
                end

                ST_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = c_iord_aluout;
                    if (mem_ready) begin
                        state_d = ST_FETCH;
                    end
                end

                ST_WB_ALU: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b0;
                    state_d    = ST_FETCH;
                end

                ST_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    state_d    = ST_FETCH;
                end

                ST_BRANCH: begin
                    // A - B sets the zero flag; target already sits in ALUOut.
                    alu_src_a = c_src_a_reg;
                    alu_src_b = c_src_b_reg;
                    alu_op    = c_alu_sub;
                    pc_src    = c_pc_src_aluout;
                    pc_write  = (w_class == CLS_BNE) ? ~zero : zero;
                    state_d   = ST_FETCH;
                end

                ST_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = c_pc_src_jump;
                    state_d  = ST_FETCH;
                end

                ST_HALT: begin
                    halted  = 1'b1;
                    state_d = ST_HALT;
                end

                // Corrupt (non one-hot) encodings recover to FETCH.
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

endmodule : multicycle_ctrl
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Directed self-checking bench for multicycle_ctrl. Each cycle
//                the full output vector is compared against a hand-written
//                expected vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       reg_write;
    logic       mem_to_reg;
    logic       halted;
    logic       illegal;

    int n_checks = 0;
    int n_errors = 0;
    logic exp_ill = 1'b0;

    multicycle_ctrl #(.OPW(4), .ALUW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .halted     (halted),
        .illegal    (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output vector layout:
    // {alu_op, src_a, src_b, ir_write, pc_write, pc_src, mem_req, mem_we,
    //  iord, reg_write, mem_to_reg, halted, illegal}
    logic [16:0] w_outs;
    assign w_outs = {alu_op, alu_src_a, alu_src_b, ir_write, pc_write, pc_src,
                     mem_req, mem_we, iord, reg_write, mem_to_reg, halted, illegal};

    function automatic logic [16:0] ov(
        input logic [2:0] op, input logic sa, input logic [1:0] sb,
        input logic irw, input logic pcw, input logic [1:0] pcs,
        input logic req, input logic we, input logic io,
        input logic rw, input logic m2r, input logic hlt);
        return {op, sa, sb, irw, pcw, pcs, req, we, io, rw, m2r, hlt, 1'b0};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply mem_ready, compare outputs mid-cycle, then advance one clock.
    task automatic step(input logic rdy, input logic [16:0] exp, input string tag);
        mem_ready = rdy;
        @(negedge clk);
        check_eq(tag, {15'b0, w_outs}, {15'b0, exp | {16'b0, exp_ill}});
        @(posedge clk);
        #1;
    endtask

    logic [16:0] e_zero, e_fetch_w, e_fetch_r, e_decode, e_exec_i;
    logic [16:0] e_mem_rd, e_mem_wr, e_wb_alu, e_wb_mem, e_jump, e_halt;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        e_zero    = 17'b0;
        e_fetch_w = ov(3'b010, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_fetch_r = ov(3'b010, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_decode  = ov(3'b010, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_exec_i  = ov(3'b010, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_mem_rd  = ov(3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        e_mem_wr  = ov(3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        e_wb_alu  = ov(3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        e_wb_mem  = ov(3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        e_jump    = ov(3'b000, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_halt    = ov(3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        rst       = 1'b1;
        opcode    = 4'h0;
        zero      = 1'b0;
        mem_ready = 1'b0;

        // Reset held for two edges; outputs idle until one edge after release.
        @(posedge clk);
        #1;
        step(1'b0, e_zero, "rst_hold");
        rst = 1'b0;
        step(1'b1, e_zero, "rst_blank");
        step(1'b0, e_fetch_w, "fetch_after_rst");

        // R-type 0x0..0x6, zero wait states: 4 cycles each.
        for (int i = 0; i < 7; i++) begin
            opcode = 4'(i);
            step(1'b1, e_fetch_r, "r_fetch");
            step(1'b1, e_decode,  "r_decode");
            step(1'b1, ov(3'(i), 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "r_exec");
            step(1'b1, e_wb_alu,  "r_wb");
        end

        // LW with 3 wait states in MEM_RD: 8 cycles.
        opcode = 4'h9;
        step(1'b1, e_fetch_r, "lw_fetch");
        step(1'b1, e_decode,  "lw_decode");
        step(1'b1, e_exec_i,  "lw_exec");
        step(1'b0, e_mem_rd,  "lw_mem_wait1");
        step(1'b0, e_mem_rd,  "lw_mem_wait2");
        step(1'b0, e_mem_rd,  "lw_mem_wait3");
        step(1'b1, e_mem_rd,  "lw_mem_ready");
        step(1'b1, e_wb_mem,  "lw_wb");

        // SW with 2 fetch wait states and 1 write wait state.
        opcode = 4'hA;
        step(1'b0, e_fetch_w, "sw_fetch_wait1");
        step(1'b0, e_fetch_w, "sw_fetch_wait2");
        step(1'b1, e_fetch_r, "sw_fetch_ready");
        step(1'b1, e_decode,  "sw_decode");
        step(1'b1, e_exec_i,  "sw_exec");
        step(1'b0, e_mem_wr,  "sw_mem_wait");
        step(1'b1, e_mem_wr,  "sw_mem_ready");

        // ADDI: 4 cycles, ends in WB_ALU.
        opcode = 4'h8;
        step(1'b1, e_fetch_r, "addi_fetch");
        step(1'b1, e_decode,  "addi_decode");
        step(1'b1, e_exec_i,  "addi_exec");
        step(1'b1, e_wb_alu,  "addi_wb");

        // Branches: BEQ taken/not taken, BNE inverted.
        opcode = 4'hB; zero = 1'b1;
        step(1'b1, e_fetch_r, "beq1_fetch");
        step(1'b1, e_decode,  "beq1_decode");
        step(1'b1, ov(3'b011, 1'b1, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "beq_taken");
        zero = 1'b0;
        step(1'b1, e_fetch_r, "beq0_fetch");
        step(1'b1, e_decode,  "beq0_decode");
        step(1'b1, ov(3'b011, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "beq_not_taken");
        opcode = 4'hC;
        step(1'b1, e_fetch_r, "bne0_fetch");
        step(1'b1, e_decode,  "bne0_decode");
        step(1'b1, ov(3'b011, 1'b1, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "bne_taken");
        zero = 1'b1;
        step(1'b1, e_fetch_r, "bne1_fetch");
        step(1'b1, e_decode,  "bne1_decode");
        step(1'b1, ov(3'b011, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "bne_not_taken");

        // Jump: 3 cycles.
        opcode = 4'hD;
        step(1'b1, e_fetch_r, "j_fetch");
        step(1'b1, e_decode,  "j_decode");
        step(1'b1, e_jump,    "j_jump");

        // Reset during a MEM_RD wait aborts the pending request.
        opcode = 4'h9;
        step(1'b1, e_fetch_r, "abort_fetch");
        step(1'b1, e_decode,  "abort_decode");
        step(1'b1, e_exec_i,  "abort_exec");
        step(1'b0, e_mem_rd,  "abort_mem_wait");
        rst = 1'b1;
        step(1'b0, e_mem_rd,  "abort_mem_rst_cycle");
        rst = 1'b0;
        step(1'b1, e_zero,    "abort_blank");
        step(1'b0, e_fetch_w, "abort_refetch");

        // Illegal opcode 0xE: back to FETCH with sticky illegal.
        opcode = 4'hE;
        step(1'b1, e_fetch_r, "ill_fetch");
        step(1'b1, e_decode,  "ill_decode");
        exp_ill = 1'b1;
        step(1'b0, e_fetch_w, "ill_back_to_fetch");
        opcode = 4'h7;
        step(1'b1, e_fetch_r, "ill7_fetch");
        step(1'b1, e_decode,  "ill7_decode");

        // HALT: stays halted with no memory requests until reset.
        opcode = 4'hF;
        step(1'b1, e_fetch_r, "halt_fetch");
        step(1'b1, e_decode,  "halt_decode");
        step(1'b1, e_halt,    "halt_1");
        step(1'b1, e_halt,    "halt_2");
        step(1'b0, e_halt,    "halt_3");
        rst = 1'b1;
        step(1'b1, e_halt,    "halt_rst_cycle");
        exp_ill = 1'b0;
        rst = 1'b0;
        step(1'b1, e_zero,    "halt_blank");
        step(1'b0, e_fetch_w, "halt_refetch");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_multicycle_ctrl
`default_nettype wire
